note_highway: RTL and testbench

//  Parametrised falling-note engine for the Guitar Hero VGA display. Keeps NUM_LANES x SLOTS note slots,

---
 rtl/note_highway_pkg.sv | 23 ++
 rtl/note_lane.sv | 97 +++++++++
 rtl/note_highway.sv | 113 +++++++++++
 tb/tb_note_highway.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/note_highway_pkg.sv
// Shared geometry defaults and small helpers for the falling-note engine.
package note_highway_pkg;

  localparam int unsigned DEF_SCREEN_H   = 480;
  localparam int unsigned DEF_LANE_X0    = 170;
  localparam int unsigned DEF_LANE_PITCH = 100;
  localparam int unsigned DEF_NOTE_W     = 50;
  localparam int unsigned DEF_NOTE_H     = 50;
  localparam int unsigned DEF_HIT_Y      = 400;

  // Lane-index width; never below 1 so a single-lane build still has a port.
  function automatic int unsigned lane_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [16:0] popcount(input logic [31:0] v);
    logic [16:0] c;
    c = '0;
    for (int unsigned i = 0; i < 32; i++) c = c + 17'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/note_lane.sv
// One lane's note slots: allocate, move, retire, strike resolution and pixel y-hit.
module note_lane
  import note_highway_pkg::*;
#(
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned Y_W      = 9,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H,
  parameter int unsigned SPAWN_Y  = 0,
  parameter int unsigned SPEED    = 1,
  parameter int unsigned NOTE_H   = DEF_NOTE_H,
  parameter int unsigned HIT_Y    = DEF_HIT_Y
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic           spawn,
  input  logic           strike,
  input  logic [Y_W-1:0] y,
  output logic           free,
  output logic           hit,
  output logic           bad_strike,
  output logic           miss,
  output logic           y_on
);

  localparam int unsigned PW = Y_W + 1;

  logic [SLOTS-1:0] valid, valid_next;
  logic [PW-1:0]    pos      [SLOTS];
  logic [PW-1:0]    pos_next [SLOTS];
  logic [PW-1:0]    moved    [SLOTS];
  logic [SLOTS-1:0] in_window, take, alloc, retire;
  logic             took, placed;

  always_comb begin
    take   = '0;
    alloc  = '0;
    took   = 1'b0;
    placed = 1'b0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      in_window[i] = valid[i] && (pos[i] >= PW'(HIT_Y))
                     && ({1'b0, pos[i]} < (PW+1)'(HIT_Y + NOTE_H));
      if (strike && in_window[i] && !took) begin
        take[i] = 1'b1;
        took    = 1'b1;
      end
      // Allocation looks at current valid bits, so a slot freed this cycle is not reused.
      if (spawn && !valid[i] && !placed) begin
        alloc[i] = 1'b1;
        placed   = 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < SLOTS; i++) begin
      moved[i]      = pos[i] + PW'(SPEED);
      retire[i]     = valid[i] && frame_tick && !take[i] && (moved[i] >= PW'(SCREEN_H));
      valid_next[i] = valid[i];
      pos_next[i]   = pos[i];
      if (take[i] || retire[i]) begin
        valid_next[i] = 1'b0;
      end else if (valid[i] && frame_tick) begin
        pos_next[i] = moved[i];
      end
      if (alloc[i]) begin
        valid_next[i] = 1'b1;
        pos_next[i]   = PW'(SPAWN_Y);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) pos[i] <= '0;
    end else begin
      valid <= valid_next;
      for (int unsigned i = 0; i < SLOTS; i++) pos[i] <= pos_next[i];
    end
  end

  always_comb begin
    y_on = 1'b0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (valid[i] && (PW'(y) >= pos[i])
          && ((PW+1)'(y) < ({1'b0, pos[i]} + (PW+1)'(NOTE_H))))
        y_on = 1'b1;
    end
  end

  assign free       = ~&valid;
  assign hit        = took;
  assign bad_strike = strike && !(|in_window);
  assign miss       = |retire;

endmodule

// File: rtl/note_highway.sv
// Falling-note engine: per-lane slot arrays, pixel lookup, result pulses and score counters.
module note_highway
  import note_highway_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned SLOTS      = 4,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 9,
  parameter int unsigned SCREEN_H   = DEF_SCREEN_H,
  parameter int unsigned SPAWN_Y    = 0,
  parameter int unsigned SPEED      = 1,
  parameter int unsigned LANE_X0    = DEF_LANE_X0,
  parameter int unsigned LANE_PITCH = DEF_LANE_PITCH,
  parameter int unsigned NOTE_W     = DEF_NOTE_W,
  parameter int unsigned NOTE_H     = DEF_NOTE_H,
  parameter int unsigned HIT_Y      = DEF_HIT_Y
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            frame_tick,
  input  logic                            spawn_valid,
  input  logic [NUM_LANES-1:0]            spawn_lanes,
  output logic                            spawn_ready,
  input  logic [NUM_LANES-1:0]            strike,
  output logic [NUM_LANES-1:0]            hit,
  output logic [NUM_LANES-1:0]            bad_strike,
  output logic [NUM_LANES-1:0]            miss,
  input  logic [X_W-1:0]                  x,
  input  logic [Y_W-1:0]                  y,
  output logic                            pixel_on,
  output logic [lane_w(NUM_LANES)-1:0]    pixel_lane,
  output logic [15:0]                     hit_count,
  output logic [15:0]                     miss_count
);

  localparam int unsigned LW = lane_w(NUM_LANES);

  logic [NUM_LANES-1:0] free, lane_spawn, hit_d, bad_d, miss_d, y_on, x_in, on_vec;
  logic                 accept, on_next, found;
  logic [LW-1:0]        lane_next;
  logic [16:0]          hit_sum, miss_sum;

  assign spawn_ready = &free;
  assign accept      = spawn_valid && spawn_ready;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam int unsigned LO = LANE_X0 + l * LANE_PITCH;

    assign lane_spawn[l] = accept && spawn_lanes[l];
    assign x_in[l] = ({1'b0, x} >= (X_W+1)'(LO)) && ({1'b0, x} < (X_W+1)'(LO + NOTE_W));

    note_lane #(
      .SLOTS    (SLOTS),
      .Y_W      (Y_W),
      .SCREEN_H (SCREEN_H),
      .SPAWN_Y  (SPAWN_Y),
      .SPEED    (SPEED),
      .NOTE_H   (NOTE_H),
      .HIT_Y    (HIT_Y)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .spawn      (lane_spawn[l]),
      .strike     (strike[l]),
      .y          (y),
      .free       (free[l]),
      .hit        (hit_d[l]),
      .bad_strike (bad_d[l]),
      .miss       (miss_d[l]),
      .y_on       (y_on[l])
    );
  end

  assign on_vec = x_in & y_on;

  always_comb begin
    on_next   = |on_vec;
    lane_next = '0;
    found     = 1'b0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      if (on_vec[l] && !found) begin
        lane_next = LW'(l);
        found     = 1'b1;
      end
    end
  end

  // Counters add the same pulses being registered, so count and pulse become visible together.
  assign hit_sum  = {1'b0, hit_count} + popcount(32'(hit_d));
  assign miss_sum = {1'b0, miss_count} + popcount(32'(miss_d)) + popcount(32'(bad_d));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit        <= '0;
      bad_strike <= '0;
      miss       <= '0;
      pixel_on   <= 1'b0;
      pixel_lane <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      hit        <= hit_d;
      bad_strike <= bad_d;
      miss       <= miss_d;
      pixel_on   <= on_next;
      pixel_lane <= lane_next;
      hit_count  <= hit_sum[16]  ? '1 : hit_sum[15:0];
      miss_count <= miss_sum[16] ? '1 : miss_sum[15:0];
    end
  end

endmodule

// File: tb/tb_note_highway.sv
// Directed self-checking bench for note_highway with default geometry.
module tb_note_highway;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        spawn_valid = 1'b0;
  logic [3:0]  spawn_lanes = '0;
  logic        spawn_ready;
  logic [3:0]  strike = '0;
  logic [3:0]  hit, bad_strike, miss;
  logic [9:0]  x = '0;
  logic [8:0]  y = '0;
  logic        pixel_on;
  logic [1:0]  pixel_lane;
  logic [15:0] hit_count, miss_count;

  int unsigned n_compared = 0;
  int unsigned n_mismatched = 0;

  note_highway dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .spawn_valid (spawn_valid),
    .spawn_lanes (spawn_lanes),
    .spawn_ready (spawn_ready),
    .strike      (strike),
    .hit         (hit),
    .bad_strike  (bad_strike),
    .miss        (miss),
    .x           (x),
    .y           (y),
    .pixel_on    (pixel_on),
    .pixel_lane  (pixel_lane),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    frame_tick = 1'b0; spawn_valid = 1'b0; spawn_lanes = '0; strike = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic spawn(input logic [3:0] lanes);
    spawn_valid = 1'b1; spawn_lanes = lanes;
    step();
    spawn_valid = 1'b0; spawn_lanes = '0;
  endtask

  task automatic ticks(input int unsigned n);
    frame_tick = 1'b1;
    repeat (n) step();
    frame_tick = 1'b0;
  endtask

  task automatic hit_strike(input logic [3:0] s);
    strike = s;
    step();
    strike = '0;
  endtask

  task automatic probe(input string tag, input int unsigned px, input int unsigned py,
                       input logic exp_on, input logic [1:0] exp_lane);
    x = 10'(px); y = 9'(py);
    step();
    check({tag, "_on"}, 32'(pixel_on), 32'(exp_on));
    check({tag, "_lane"}, 32'(pixel_lane), 32'(exp_lane));
  endtask

  initial begin
    // 1: reset mid-run with three live notes
    do_reset();
    check("rst_ready", 32'(spawn_ready), 32'd1);
    check("rst_miss_count", 32'(miss_count), 32'd0);
    spawn(4'b0111);
    ticks(10);
    probe("t1_live", 175, 10, 1'b1, 2'd0);
    hit_strike(4'b0001);
    check("t1_bad_pre", 32'(bad_strike), 32'b0001);
    check("t1_mcount_pre", 32'(miss_count), 32'd1);
    x = 10'd175; y = 9'd10;
    #2 reset = 1'b1;
    #1;
    check("t1_hit", 32'(hit), 32'd0);
    check("t1_bad", 32'(bad_strike), 32'd0);
    check("t1_miss", 32'(miss), 32'd0);
    check("t1_pix", 32'(pixel_on), 32'd0);
    check("t1_mcount", 32'(miss_count), 32'd0);
    check("t1_ready", 32'(spawn_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    probe("t1_after", 175, 10, 1'b0, 2'd0);
    probe("t1_after2", 375, 10, 1'b0, 2'd0);

    // 2: two-lane spawn and pixel lookup after 430 ticks
    do_reset();
    spawn(4'b0101);
    ticks(430);
    probe("t2_l0", 175, 440, 1'b1, 2'd0);
    probe("t2_l2", 375, 440, 1'b1, 2'd2);
    probe("t2_l1", 275, 440, 1'b0, 2'd0);
    probe("t2_xedge", 220, 440, 1'b0, 2'd0);
    probe("t2_ytop", 175, 429, 1'b0, 2'd0);
    probe("t2_ybot", 175, 479, 1'b1, 2'd0);

    // 3: strike window edges, hit and bad strike
    do_reset();
    spawn(4'b0010);
    ticks(399);
    hit_strike(4'b0010);
    check("t3_early_bad", 32'(bad_strike), 32'b0010);
    check("t3_early_hit", 32'(hit), 32'd0);
    ticks(1);
    hit_strike(4'b0010);
    check("t3_hit", 32'(hit), 32'b0010);
    check("t3_hcount", 32'(hit_count), 32'd1);
    step();
    check("t3_hit_pulse", 32'(hit), 32'd0);
    hit_strike(4'b0010);
    check("t3_bad", 32'(bad_strike), 32'b0010);
    check("t3_mcount", 32'(miss_count), 32'd2);

    // 4: note retires off screen
    do_reset();
    spawn(4'b1000);
    ticks(479);
    check("t4_no_miss", 32'(miss), 32'd0);
    ticks(1);
    check("t4_miss", 32'(miss), 32'b1000);
    check("t4_mcount", 32'(miss_count), 32'd1);
    step();
    check("t4_miss_pulse", 32'(miss), 32'd0);
    probe("t4_gone", 475, 500, 1'b0, 2'd0);

    // 5: full lane blocks spawns until a retire frees a slot
    do_reset();
    spawn(4'b0100); ticks(1);
    spawn(4'b0100); ticks(1);
    spawn(4'b0100); ticks(1);
    check("t5_ready3", 32'(spawn_ready), 32'd1);
    spawn(4'b0100);
    check("t5_full", 32'(spawn_ready), 32'd0);
    spawn(4'b0001);
    probe("t5_held", 175, 0, 1'b0, 2'd0);
    probe("t5_l2", 375, 0, 1'b1, 2'd2);
    ticks(476);
    check("t5_still_full", 32'(spawn_ready), 32'd0);
    ticks(1);
    check("t5_miss", 32'(miss), 32'b0100);
    check("t5_ready", 32'(spawn_ready), 32'd1);

    // 6: strike and tick together at the last window row
    do_reset();
    spawn(4'b0001);
    ticks(449);
    strike = 4'b0001; frame_tick = 1'b1;
    step();
    strike = '0; frame_tick = 1'b0;
    check("t6_hit", 32'(hit), 32'b0001);
    check("t6_miss", 32'(miss), 32'd0);
    check("t6_hcount", 32'(hit_count), 32'd1);
    check("t6_mcount", 32'(miss_count), 32'd0);
    probe("t6_freed", 175, 449, 1'b0, 2'd0);

    // 7: spawn and tick together: old note moves, new one stays at the top
    do_reset();
    spawn(4'b0001);
    ticks(100);
    spawn_valid = 1'b1; spawn_lanes = 4'b0001; frame_tick = 1'b1;
    step();
    spawn_valid = 1'b0; spawn_lanes = '0; frame_tick = 1'b0;
    probe("t7_new", 175, 0, 1'b1, 2'd0);
    probe("t7_new_h", 175, 50, 1'b0, 2'd0);
    probe("t7_old_moved", 175, 100, 1'b0, 2'd0);
    probe("t7_old", 175, 101, 1'b1, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
